// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA execution controller: ULA operation codes,
// the controller state type and small helpers for writeback and carry rules.
// ---------------------------------------------------------------------------
package ula_pkg;

    localparam logic [3:0] ULA_PASS   = 4'd0;
    localparam logic [3:0] ULA_INC    = 4'd1;
    localparam logic [3:0] ULA_ADD    = 4'd2;
    localparam logic [3:0] ULA_ADDC1  = 4'd3;
    localparam logic [3:0] ULA_ADDNOT = 4'd4;
    localparam logic [3:0] ULA_SUB    = 4'd5;
    localparam logic [3:0] ULA_DEC    = 4'd6;
    localparam logic [3:0] ULA_MUL    = 4'd7;
    localparam logic [3:0] ULA_AND    = 4'd8;
    localparam logic [3:0] ULA_OR     = 4'd9;
    localparam logic [3:0] ULA_XOR    = 4'd10;
    localparam logic [3:0] ULA_NOT    = 4'd11;
    localparam logic [3:0] ULA_SHL    = 4'd12;
    localparam logic [3:0] ULA_SHR    = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        MULHI = 2'd2
    } state_t;

    // Codes 14 and 15 are NOPs: no register write, flags untouched.
    function automatic logic writes_back(input logic [3:0] op);
        return (op <= ULA_SHR);
    endfunction

    // Carry source depends on the operation class; shifts report the bit
    // shifted out of the operand, logic ops and pass clear it.
    function automatic logic carry_of(input logic [3:0]  op,
                                      input logic [7:0]  a,
                                      input logic [15:0] s);
        logic c;
        c = 1'b0;
        if ((op >= ULA_INC) && (op <= ULA_DEC)) c = s[8];
        else if (op == ULA_MUL)                 c = |s[15:8];
        else if (op == ULA_SHL)                 c = a[7];
        else if (op == ULA_SHR)                 c = a[0];
        return c;
    endfunction

endpackage

// File: rtl/ula_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// ula_exec_ctrl_if
// Instruction handshake bundle between an instruction source (master) and
// the execution controller (slave).
//   instr_valid  : instruction present (master -> slave)
//   instr_ready  : controller can accept (slave -> master)
//   instr_op     : ULA operation code
//   instr_rd     : destination register, also source of operand A
//   instr_rs     : source register for operand B
//   instr_imm_en : select immediate for operand B
//   instr_imm    : immediate operand
// ---------------------------------------------------------------------------
interface ula_exec_ctrl_if;

    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic       instr_imm_en;
    logic [7:0] instr_imm;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs, instr_imm_en, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs, instr_imm_en, instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/ula_regbank.sv
// ---------------------------------------------------------------------------
// ula_regbank
// 4 x 8-bit register bank with asynchronous active-high reset.
//   clk, rst   : clock, async reset (clears all registers)
//   we/waddr/wdata : single write port, written at the rising edge
//   raddr_a/rdata_a, raddr_b/rdata_b : operand read ports (combinational)
//   raddr_dbg/rdata_dbg              : debug read port (combinational)
// ---------------------------------------------------------------------------
module ula_regbank (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    input  logic [1:0] raddr_dbg,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    output logic [7:0] rdata_dbg
);

    logic [7:0] regs [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = regs[raddr_a];
    assign rdata_b   = regs[raddr_b];
    assign rdata_dbg = regs[raddr_dbg];

endmodule

// File: rtl/ula_exec_ctrl.sv
// ---------------------------------------------------------------------------
// ula_exec_ctrl
// Sequencing stage upstream of the 8-bit ULA. Accepts one instruction at a
// time, fetches operands from a 4 x 8 register bank or an immediate, drives
// the ULA inputs, then writes the ULA result back and updates Z/C. Multiply
// writes its high byte to the pair register (rd ^ 1) in an extra cycle.
//   clk, rst           : clock, async active-high reset
//   instr (slave)      : instruction handshake bundle
//   alu_a/alu_b/alu_sula : registered ULA inputs
//   alu_s              : ULA output [7:0] result, [8] carry, [15:8] product high
//   flag_z, flag_c     : zero / carry flags
//   done               : one-cycle pulse after the final write edge
//   dbg_sel/dbg_data   : combinational debug read of R[dbg_sel]
//
// state | meaning
// IDLE  | ready; latch operands and op on an accepted instruction
// EXEC  | ULA evaluating; write low byte and flags at the closing edge
// MULHI | write multiply high byte to rd ^ 1
// ---------------------------------------------------------------------------
module ula_exec_ctrl
    import ula_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ula_exec_ctrl_if.slave        instr,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [3:0]            alu_sula,
    input  logic [15:0]           alu_s,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  done,
    input  logic [1:0]            dbg_sel,
    output logic [7:0]            dbg_data
);

    state_t     state;
    logic [1:0] rd_q;
    logic [7:0] hi_q;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata_a;
    logic [7:0] rf_rdata_b;

    assign instr.instr_ready = (state == IDLE);

    // The bank is written at the closing edge of EXEC (low byte) and of
    // MULHI (high byte into the pair register).
    assign rf_we    = ((state == EXEC) && writes_back(alu_sula)) || (state == MULHI);
    assign rf_waddr = (state == MULHI) ? (rd_q ^ 2'b01) : rd_q;
    assign rf_wdata = (state == MULHI) ? hi_q : alu_s[7:0];

    ula_regbank u_regbank (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (instr.instr_rd),
        .raddr_b   (instr.instr_rs),
        .raddr_dbg (dbg_sel),
        .rdata_a   (rf_rdata_a),
        .rdata_b   (rf_rdata_b),
        .rdata_dbg (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            alu_a    <= 8'h00;
            alu_b    <= 8'h00;
            alu_sula <= 4'h0;
            rd_q     <= 2'd0;
            hi_q     <= 8'h00;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr.instr_valid) begin
                        alu_a    <= rf_rdata_a;
                        alu_b    <= instr.instr_imm_en ? instr.instr_imm : rf_rdata_b;
                        alu_sula <= instr.instr_op;
                        rd_q     <= instr.instr_rd;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (writes_back(alu_sula)) begin
                        flag_z <= (alu_s[7:0] == 8'h00);
                        flag_c <= carry_of(alu_sula, alu_a, alu_s);
                    end
                    if (alu_sula == ULA_MUL) begin
                        hi_q  <= alu_s[15:8];
                        state <= MULHI;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                MULHI: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_exec_ctrl.sv
module tb_ula_exec_ctrl;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sula;
    logic [15:0] alu_s;
    logic        flag_z, flag_c, done;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    ula_exec_ctrl_if instr_bus ();

    ula_exec_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr_bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sula (alu_sula),
        .alu_s    (alu_s),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .done     (done),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ULA sitting between alu_* and alu_s.
    function automatic logic [15:0] ula_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  t;
        logic [15:0] s;
        t = 9'h000;
        s = 16'h0000;
        case (op)
            4'd0:  s = {8'h00, a};
            4'd1:  begin t = {1'b0, a} + 9'd1;                  s = {7'h00, t}; end
            4'd2:  begin t = {1'b0, a} + {1'b0, b};             s = {7'h00, t}; end
            4'd3:  begin t = {1'b0, a} + {1'b0, b} + 9'd1;      s = {7'h00, t}; end
            4'd4:  begin t = {1'b0, a} + {1'b0, ~b};            s = {7'h00, t}; end
            4'd5:  begin t = {1'b0, a} + {1'b0, ~b} + 9'd1;     s = {7'h00, t}; end
            4'd6:  begin t = {1'b0, a} + 9'h0FF;                s = {7'h00, t}; end
            4'd7:  s = {8'h00, a} * {8'h00, b};
            4'd8:  s = {8'h00, a & b};
            4'd9:  s = {8'h00, a | b};
            4'd10: s = {8'h00, a ^ b};
            4'd11: s = {8'h00, ~a};
            4'd12: s = {8'h00, a[6:0], 1'b0};
            4'd13: s = {9'h000, a[7:1]};
            default: s = 16'h0000;
        endcase
        return s;
    endfunction

    assign alu_s = ula_f(alu_sula, alu_a, alu_b);

    typedef struct packed {
        logic [3:0][7:0] regs;
        logic            z;
        logic            c;
        logic [31:0]     done_cyc;
    } exp_t;

    exp_t        sb_q [$];
    logic [7:0]  m_r [4];
    logic        m_z, m_c;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          issued = 0;
    int          accepted = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (!rst && instr_bus.instr_valid && instr_bus.instr_ready) accepted <= accepted + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules.
    task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                              input logic imm_en, input logic [7:0] imm, input int acc_edge);
        logic [7:0]  a, b;
        logic [15:0] s;
        exp_t        e;
        a = m_r[rd];
        b = imm_en ? imm : m_r[rs];
        s = ula_f(op, a, b);
        if (op <= 4'd13) begin
            m_r[rd] = s[7:0];
            m_z = (s[7:0] == 8'h00);
            if (op >= 4'd1 && op <= 4'd6) m_c = s[8];
            else if (op == 4'd7)          m_c = (s[15:8] != 8'h00);
            else if (op == 4'd12)         m_c = a[7];
            else if (op == 4'd13)         m_c = a[0];
            else                          m_c = 1'b0;
        end
        if (op == 4'd7) m_r[rd ^ 2'b01] = s[15:8];
        for (int i = 0; i < 4; i++) e.regs[i] = m_r[i];
        e.z = m_z;
        e.c = m_c;
        e.done_cyc = acc_edge + ((op == 4'd7) ? 2 : 1);
        sb_q.push_back(e);
    endtask

    // Presents an instruction and leaves instr_valid high after acceptance.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic imm_en, input logic [7:0] imm);
        int t;
        @(negedge clk);
        instr_bus.instr_op     = op;
        instr_bus.instr_rd     = rd;
        instr_bus.instr_rs     = rs;
        instr_bus.instr_imm_en = imm_en;
        instr_bus.instr_imm    = imm;
        instr_bus.instr_valid  = 1'b1;
        t = 0;
        while (!instr_bus.instr_ready) begin
            @(negedge clk);
            t++;
            if (t > 10) begin
                $display("FAIL ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
                $fatal(1, "instr_ready never returned");
            end
        end
        model_exec(op, rd, rs, imm_en, imm, cyc + 1);
        issued++;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        instr_bus.instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: owns dbg_sel, pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        dbg_sel = 2'd0;
        @(negedge rst);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1 chk("reset_reg", {24'h0, dbg_data}, 32'h0);
        end
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("flag_z", {31'h0, flag_z}, {31'h0, e.z});
                    chk("flag_c", {31'h0, flag_c}, {31'h0, e.c});
                    for (int i = 0; i < 4; i++) begin
                        dbg_sel = i[1:0];
                        #1 chk("reg", {24'h0, dbg_data}, {24'h0, e.regs[i]});
                    end
                end
            end
        end
    end

    initial begin
        int t;
        instr_bus.instr_valid  = 1'b0;
        instr_bus.instr_op     = 4'h0;
        instr_bus.instr_rd     = 2'd0;
        instr_bus.instr_rs     = 2'd0;
        instr_bus.instr_imm_en = 1'b0;
        instr_bus.instr_imm    = 8'h00;
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", {31'h0, instr_bus.instr_ready}, 32'h1);
        chk("reset_flag_z", {31'h0, flag_z}, 32'h0);
        chk("reset_flag_c", {31'h0, flag_c}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_alu", {12'h0, alu_sula, alu_b, alu_a}, 32'h0);
        repeat (2) @(negedge clk);

        // Directed: load R0/R1, add with carry out
        issue(4'd2, 2'd0, 2'd0, 1'b1, 8'hF0);
        issue(4'd2, 2'd1, 2'd0, 1'b1, 8'h20);
        issue(4'd2, 2'd0, 2'd1, 1'b0, 8'h00);
        // Multiply into pair {2,3}
        issue(4'd2, 2'd2, 2'd0, 1'b1, 8'h10);
        issue(4'd7, 2'd2, 2'd0, 1'b1, 8'h20);
        // Shifts
        issue(4'd8, 2'd0, 2'd0, 1'b1, 8'h00);
        issue(4'd2, 2'd0, 2'd0, 1'b1, 8'h81);
        issue(4'd13, 2'd0, 2'd0, 1'b0, 8'h00);
        issue(4'd12, 2'd0, 2'd0, 1'b0, 8'h00);
        // NOP with valid held across several cycles
        issue(4'd15, 2'd1, 2'd1, 1'b1, 8'hAA);
        issue(4'd15, 2'd1, 2'd1, 1'b1, 8'hAA);
        issue(4'd15, 2'd1, 2'd1, 1'b1, 8'hAA);
        idle(3);

        // Reset during EXEC of an add aborts it
        @(negedge clk);
        instr_bus.instr_op     = 4'd2;
        instr_bus.instr_rd     = 2'd3;
        instr_bus.instr_rs     = 2'd1;
        instr_bus.instr_imm_en = 1'b0;
        instr_bus.instr_valid  = 1'b1;
        @(posedge clk);
        issued++;
        @(negedge clk);
        instr_bus.instr_valid = 1'b0;
        chk("exec_op_latched", {28'h0, alu_sula}, 32'h2);
        rst = 1'b1;
        #1;
        chk("abort_alu", {12'h0, alu_sula, alu_b, alu_a}, 32'h0);
        chk("abort_flags", {30'h0, flag_z, flag_c}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_ready", {31'h0, instr_bus.instr_ready}, 32'h1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(4'd14, 2'd0, 2'd0, 1'b0, 8'h00);

        // Randomized phase
        for (int n = 0; n < 300; n++) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        idle(1);

        t = 0;
        while (sb_q.size() != 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        chk("accept_count", accepted, issued);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
